// File: rtl/mips_pipe_pkg.sv
// Opcode/funct encodings used by the hazard unit, plus small decode helpers
// shared by the RTL and the testbench.
package mips_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // HI/LO moves and MULT/DIV all touch the MDU and must wait while it is busy.
  function automatic logic is_mdu_op(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_RTYPE) &&
           (((funct >= FN_MFHI) && (funct <= FN_MTLO)) ||
            ((funct >= FN_MULT) && (funct <= FN_DIVU)));
  endfunction

  function automatic logic is_jump_op(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_J) || (opcode == OP_JAL) ||
           ((opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR)));
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter with a synchronous clear that overrides increment.
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard controller: load-use scoreboard, MULT/DIV busy tracking,
// stall/bubble/flush generation and saturating stall/flush counters.
module hazard_scoreboard_unit
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int MDU_LAT    = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [5:0]            id_opcode,
  input  logic [5:0]            id_funct,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_wr_reg,
  input  logic                  ex_branch,
  input  logic                  ex_zero,
  input  logic                  ex_mdu_start,
  input  logic                  cnt_clr,
  output logic                  stall_if_id,
  output logic                  bubble_id_ex,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  mdu_busy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int MDU_W = $clog2(MDU_LAT);

  logic                  slot0_v;
  logic [LOAD_LAT-1:0]   slot_hit;
  logic                  load_haz;
  logic                  mdu_haz;
  logic                  br_taken;
  logic                  jump;
  logic [MDU_W-1:0]      mdu_cnt_reg;

  function automatic logic src_match(input logic [REG_ADDR_W-1:0] rd);
    return (id_uses_rs && (id_rs == rd)) || (id_uses_rt && (id_rt == rd));
  endfunction

  // Slot 0 is the load currently in EX; a write to $0 never creates a hazard.
  assign slot0_v     = ex_valid & ex_mem_read & (ex_wr_reg != '0);
  assign slot_hit[0] = slot0_v & src_match(ex_wr_reg);

  generate
    if (LOAD_LAT > 1) begin : g_shift
      logic [LOAD_LAT-1:1]   pend_v_reg;
      logic [REG_ADDR_W-1:0] pend_rd_reg [1:LOAD_LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_v_reg <= '0;
          for (int k = 1; k < LOAD_LAT; k++) pend_rd_reg[k] <= '0;
        end else begin
          pend_v_reg[1]  <= slot0_v;
          pend_rd_reg[1] <= ex_wr_reg;
          for (int k = 2; k < LOAD_LAT; k++) begin
            pend_v_reg[k]  <= pend_v_reg[k-1];
            pend_rd_reg[k] <= pend_rd_reg[k-1];
          end
        end
      end

      for (genvar gi = 1; gi < LOAD_LAT; gi++) begin : g_hit
        assign slot_hit[gi] = pend_v_reg[gi] & src_match(pend_rd_reg[gi]);
      end
    end
  endgenerate

  assign load_haz = id_valid & (|slot_hit);

  // A new start while busy simply restarts the occupancy window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt_reg <= '0;
    end else if (ex_mdu_start) begin
      mdu_cnt_reg <= MDU_W'(MDU_LAT - 1);
    end else if (mdu_cnt_reg != '0) begin
      mdu_cnt_reg <= mdu_cnt_reg - 1'b1;
    end
  end

  assign mdu_busy = (mdu_cnt_reg != '0);
  assign mdu_haz  = id_valid & mdu_busy & is_mdu_op(id_opcode, id_funct);
  assign br_taken = ex_valid & ex_branch & ex_zero;
  assign jump     = id_valid & is_jump_op(id_opcode, id_funct);

  // Taken branch kills the ID instruction, so its stall is moot; a stall
  // holds the jump in ID so it must not redirect yet.
  always_comb begin
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    if (br_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_haz || mdu_haz) begin
      stall_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (jump) begin
      flush_if_id = 1'b1;
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_if_id),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_if_id),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

endmodule
